// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: in-order pipeline hazard controller.
// Produces per-register hold (stall) and bubble (flush) enables from
// per-stage ready and control-transfer redirects, tracks stage occupancy,
// and keeps saturating stall/retire/redirect event counters.
// Ready semantics: stage_ready[i]=1 means stage i can hand its contents on
// this cycle; a not-ready stage holds itself and every older (lower-index)
// stage. An empty stage's not-ready can be ignored (MASK_IDLE=1).
module pipe_ctrl_n #(
   parameter int STAGES    = 5,
   parameter int CNT_W     = 32,
   parameter int MASK_IDLE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [STAGES-1:0]          stage_ready,
   input  logic                       fetch_valid,
   input  logic                       redirect_valid,
   input  logic [$clog2(STAGES)-1:0]  redirect_stage,
   input  logic                       cnt_clr,
   output logic [STAGES-1:0]          stage_stall,
   output logic [STAGES-1:0]          stage_flush,
   output logic [STAGES-1:0]          stage_valid,
   output logic                       retire_valid,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           retire_cnt,
   output logic [CNT_W-1:0]           redirect_cnt
);

   localparam int              RS_W     = $clog2(STAGES);
   localparam logic [RS_W-1:0] LAST_IDX = RS_W'(STAGES - 1);
   localparam logic            MASK_BIT = (MASK_IDLE != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Occupancy of the registers in front of stages 1..STAGES-1.
   logic [STAGES-1:1] valid_q, valid_d;
   logic [STAGES-1:0] er;
   logic [RS_W-1:0]   rs;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

   assign stage_valid = {valid_q, fetch_valid};

   // Effective ready: an empty downstream stage never blocks when masking is on.
   always_comb begin
      er    = '0;
      er[0] = stage_ready[0];
      for (int i = 1; i < STAGES; i++) begin
         er[i] = stage_ready[i] | (MASK_BIT & ~valid_q[i]);
      end
   end

   // Stall propagates from the youngest blocked stage back to fetch.
   always_comb begin
      logic blk;
      blk         = 1'b0;
      stage_stall = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         blk            = blk | ~er[i];
         stage_stall[i] = blk;
      end
   end

   // Bubble at the stall boundary, plus redirect flush of registers 1..rs.
   always_comb begin
      rs          = (redirect_stage > LAST_IDX) ? LAST_IDX : redirect_stage;
      stage_flush = '0;
      for (int i = 1; i < STAGES; i++) begin
         stage_flush[i] = (stage_stall[i-1] & ~stage_stall[i]) |
                          (redirect_valid & (i <= int'(rs)));
      end
   end

   // Next occupancy: flush beats hold; otherwise shift from the older stage.
   always_comb begin
      valid_d = valid_q;
      for (int i = 1; i < STAGES; i++) begin
         if (stage_flush[i])       valid_d[i] = 1'b0;
         else if (!stage_stall[i]) valid_d[i] = stage_valid[i-1];
      end
   end

   assign retire_valid = valid_q[STAGES-1] & ~stage_stall[STAGES-1];

   // Saturating event counters; clear has priority over increment.
   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      retire_cnt_d   = retire_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d    = '0;
         retire_cnt_d   = '0;
         redirect_cnt_d = '0;
      end else begin
         if (stage_stall[0] && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
         if (retire_valid && retire_cnt_q != CNT_MAX)
            retire_cnt_d = retire_cnt_q + 1'b1;
         if (redirect_valid && redirect_cnt_q != CNT_MAX)
            redirect_cnt_d = redirect_cnt_q + 1'b1;
      end
   end

   // State registers; reset empties the pipe and zeroes counters at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q        <= '0;
         stall_cnt_q    <= '0;
         retire_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         valid_q        <= valid_d;
         stall_cnt_q    <= stall_cnt_d;
         retire_cnt_q   <= retire_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign retire_cnt   = retire_cnt_q;
   assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed vector table, hand-written corner
// sequences, and randomized traffic against a reference model, with one
// instance using idle masking and one using raw ready.
module tb_pipe_ctrl_n;

   localparam int S  = 5;
   localparam int CW = 8;
   localparam int RW = $clog2(S);
   localparam int CMAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [S-1:0]  stage_ready;
   logic          fetch_valid, redirect_valid, cnt_clr;
   logic [RW-1:0] redirect_stage;

   logic [S-1:0]  st1, fl1, va1;
   logic          rt1;
   logic [CW-1:0] sc1, rc1, dc1;
   logic [S-1:0]  st0, fl0, va0;
   logic          rt0;
   logic [CW-1:0] sc0, rc0, dc0;

   pipe_ctrl_n #(.STAGES(S), .CNT_W(CW), .MASK_IDLE(1)) dut (
      .clk(clk), .rst(rst), .stage_ready(stage_ready), .fetch_valid(fetch_valid),
      .redirect_valid(redirect_valid), .redirect_stage(redirect_stage), .cnt_clr(cnt_clr),
      .stage_stall(st1), .stage_flush(fl1), .stage_valid(va1), .retire_valid(rt1),
      .stall_cnt(sc1), .retire_cnt(rc1), .redirect_cnt(dc1));

   pipe_ctrl_n #(.STAGES(S), .CNT_W(CW), .MASK_IDLE(0)) dut_raw (
      .clk(clk), .rst(rst), .stage_ready(stage_ready), .fetch_valid(fetch_valid),
      .redirect_valid(redirect_valid), .redirect_stage(redirect_stage), .cnt_clr(cnt_clr),
      .stage_stall(st0), .stage_flush(fl0), .stage_valid(va0), .retire_valid(rt0),
      .stall_cnt(sc0), .retire_cnt(rc0), .redirect_cnt(dc0));

   int n_total = 0;
   int n_pass  = 0;

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic f, input logic [S-1:0] rdy, input logic rv,
                        input logic [RW-1:0] rs, input logic clr);
      fetch_valid    = f;
      stage_ready    = rdy;
      redirect_valid = rv;
      redirect_stage = rs;
      cnt_clr        = clr;
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, '1, 1'b0, '0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // Index 0 models the masked instance, index 1 the raw-ready instance.
   bit mv[2][S];
   int msc[2], mrc[2], mdc[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < S; i++) mv[k][i] = 0;
         msc[k] = 0; mrc[k] = 0; mdc[k] = 0;
      end
   endtask

   // The youngest blocked stage (hb) decides everything: every register at or
   // older than it holds, the one just younger takes a bubble.
   task automatic model_eval(input int k, output logic [S-1:0] st, output logic [S-1:0] fl,
                             output logic [S-1:0] vl, output logic rt, output int hb);
      int  rsc;
      bit  blocked;
      hb  = -1;
      rsc = (int'(redirect_stage) > S - 1) ? S - 1 : int'(redirect_stage);
      for (int i = 0; i < S; i++) begin
         if (i == 0) blocked = !stage_ready[0];
         else        blocked = !stage_ready[i] && (mv[k][i] || k == 1);
         if (blocked) hb = i;
      end
      for (int i = 0; i < S; i++) begin
         st[i] = (i <= hb);
         fl[i] = (i >= 1) && ((i == hb + 1) || (redirect_valid && i <= rsc));
         vl[i] = (i == 0) ? fetch_valid : mv[k][i];
      end
      rt = mv[k][S-1] && (hb < S - 1);
   endtask

   task automatic model_step(input int k);
      logic [S-1:0] st, fl, vl;
      logic rt;
      int   hb;
      bit   nv[S];
      model_eval(k, st, fl, vl, rt, hb);
      for (int i = 1; i < S; i++) begin
         if (fl[i])      nv[i] = 0;
         else if (i > hb) nv[i] = vl[i-1];
         else            nv[i] = mv[k][i];
      end
      for (int i = 1; i < S; i++) mv[k][i] = nv[i];
      if (cnt_clr) begin
         msc[k] = 0; mrc[k] = 0; mdc[k] = 0;
      end else begin
         if (st[0])          msc[k] = (msc[k] + 1 > CMAX) ? CMAX : msc[k] + 1;
         if (rt)             mrc[k] = (mrc[k] + 1 > CMAX) ? CMAX : mrc[k] + 1;
         if (redirect_valid) mdc[k] = (mdc[k] + 1 > CMAX) ? CMAX : mdc[k] + 1;
      end
   endtask

   task automatic check_model(input int k);
      logic [S-1:0] st, fl, vl;
      logic rt;
      int   hb;
      model_eval(k, st, fl, vl, rt, hb);
      if (k == 0) begin
         chk("rnd_m_stall", 32'(st1), 32'(st));
         chk("rnd_m_flush", 32'(fl1), 32'(fl));
         chk("rnd_m_valid", 32'(va1), 32'(vl));
         chk("rnd_m_retire", 32'(rt1), 32'(rt));
         chk("rnd_m_stall_cnt", 32'(sc1), 32'(msc[0]));
         chk("rnd_m_retire_cnt", 32'(rc1), 32'(mrc[0]));
         chk("rnd_m_redirect_cnt", 32'(dc1), 32'(mdc[0]));
      end else begin
         chk("rnd_r_stall", 32'(st0), 32'(st));
         chk("rnd_r_flush", 32'(fl0), 32'(fl));
         chk("rnd_r_valid", 32'(va0), 32'(vl));
         chk("rnd_r_retire", 32'(rt0), 32'(rt));
         chk("rnd_r_stall_cnt", 32'(sc0), 32'(msc[1]));
         chk("rnd_r_retire_cnt", 32'(rc0), 32'(mrc[1]));
         chk("rnd_r_redirect_cnt", 32'(dc0), 32'(mdc[1]));
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          f;
      logic [S-1:0]  rdy;
      logic          rv;
      logic [RW-1:0] rs;
      logic          clr;
      logic [S-1:0]  e_stall;
      logic [S-1:0]  e_flush;
      logic [S-1:0]  e_valid;
      logic          e_ret;
      int            e_sc;
      int            e_rc;
      int            e_dc;
   } vec_t;

   vec_t tbl[16];

   initial begin
      // fill, back-pressure, redirects, idle ready, rs=0, clear
      tbl[0]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1'b0, 0, 0, 0};
      tbl[1]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00011, 1'b0, 0, 0, 0};
      tbl[2]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00111, 1'b0, 0, 0, 0};
      tbl[3]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b01111, 1'b0, 0, 0, 0};
      tbl[4]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b11111, 1'b1, 0, 0, 0};
      tbl[5]  = '{1'b1, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b11111, 1'b1, 0, 1, 0};
      tbl[6]  = '{1'b1, 5'b10111, 1'b0, 3'd0, 1'b0, 5'b01111, 5'b10000, 5'b11111, 1'b1, 0, 2, 0};
      tbl[7]  = '{1'b1, 5'b10111, 1'b0, 3'd0, 1'b0, 5'b01111, 5'b10000, 5'b01111, 1'b0, 1, 3, 0};
      tbl[8]  = '{1'b1, 5'b10111, 1'b0, 3'd0, 1'b0, 5'b01111, 5'b10000, 5'b01111, 1'b0, 2, 3, 0};
      tbl[9]  = '{1'b1, 5'b11111, 1'b1, 3'd2, 1'b0, 5'b00000, 5'b00110, 5'b01111, 1'b0, 3, 3, 0};
      tbl[10] = '{1'b1, 5'b11111, 1'b1, 3'd7, 1'b0, 5'b00000, 5'b11110, 5'b11001, 1'b1, 3, 3, 1};
      tbl[11] = '{1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00001, 5'b00010, 5'b00000, 1'b0, 3, 4, 2};
      tbl[12] = '{1'b0, 5'b00001, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0, 4, 4, 2};
      tbl[13] = '{1'b1, 5'b11111, 1'b1, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00001, 1'b0, 4, 4, 2};
      tbl[14] = '{1'b0, 5'b11111, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00010, 1'b0, 4, 4, 3};
      tbl[15] = '{1'b0, 5'b11111, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00100, 1'b0, 0, 0, 0};
   end

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1;
      drive(1'b0, '1, 1'b0, '0, 1'b0);
      #1;

      // Reset state
      do_reset();
      #2;
      chk("reset_valid", 32'(va1), 32'h0);
      chk("reset_stall_cnt", 32'(sc1), 32'h0);
      chk("reset_retire_cnt", 32'(rc1), 32'h0);
      chk("reset_redirect_cnt", 32'(dc1), 32'h0);
      tick();

      // Directed table
      do_reset();
      for (int v = 0; v < 16; v++) begin
         drive(tbl[v].f, tbl[v].rdy, tbl[v].rv, tbl[v].rs, tbl[v].clr);
         #2;
         chk($sformatf("tbl%0d_stall", v), 32'(st1), 32'(tbl[v].e_stall));
         chk($sformatf("tbl%0d_flush", v), 32'(fl1), 32'(tbl[v].e_flush));
         chk($sformatf("tbl%0d_valid", v), 32'(va1), 32'(tbl[v].e_valid));
         chk($sformatf("tbl%0d_retire", v), 32'(rt1), 32'(tbl[v].e_ret));
         chk($sformatf("tbl%0d_stall_cnt", v), 32'(sc1), 32'(tbl[v].e_sc));
         chk($sformatf("tbl%0d_retire_cnt", v), 32'(rc1), 32'(tbl[v].e_rc));
         chk($sformatf("tbl%0d_redirect_cnt", v), 32'(dc1), 32'(tbl[v].e_dc));
         tick();
      end

      // Idle mask on an empty pipe, and stall/flush while held in reset
      do_reset();
      drive(1'b0, 5'b00001, 1'b0, '0, 1'b0);
      #2;
      chk("idle_masked_stall", 32'(st1), 32'h00);
      chk("idle_raw_stall", 32'(st0), 32'h1f);
      chk("idle_raw_flush", 32'(fl0), 32'h00);
      rst = 1'b1;
      #1;
      chk("inreset_flush", 32'(fl1), 32'h00);
      drive(1'b0, 5'b00000, 1'b0, '0, 1'b0);
      #1;
      chk("inreset_stall", 32'(st1), 32'h01);
      tick();

      // Saturation, then clear with stall active
      do_reset();
      drive(1'b0, 5'b00000, 1'b0, '0, 1'b0);
      repeat (300) tick();
      chk("sat_stall_cnt", 32'(sc1), 32'(CMAX));
      chk("sat_raw_stall_cnt", 32'(sc0), 32'(CMAX));
      cnt_clr = 1'b1;
      tick();
      chk("clr_stall_cnt", 32'(sc1), 32'h0);
      cnt_clr = 1'b0;
      tick();
      chk("after_clr_stall_cnt", 32'(sc1), 32'h1);

      // Asynchronous reset mid-stall, then restart from empty
      do_reset();
      drive(1'b1, 5'b11111, 1'b0, '0, 1'b0);
      repeat (5) tick();
      drive(1'b1, 5'b10111, 1'b0, '0, 1'b0);
      repeat (2) tick();
      #2;
      chk("pre_async_stall_cnt", 32'(sc1), 32'h2);
      #1;
      rst = 1'b1;
      #1;
      chk("async_valid", 32'(va1), 32'h01);
      chk("async_stall_cnt", 32'(sc1), 32'h0);
      chk("async_retire_cnt", 32'(rc1), 32'h0);
      chk("async_stall_masked", 32'(st1), 32'h00);
      tick();
      rst = 1'b0;
      drive(1'b1, 5'b11111, 1'b0, '0, 1'b0);
      tick();
      #1;
      chk("post_reset_valid", 32'(va1), 32'h03);
      chk("post_reset_retire_cnt", 32'(rc1), 32'h0);
      chk("post_reset_stall_cnt", 32'(sc1), 32'h0);

      // Randomized traffic against the model, both instances
      do_reset();
      model_reset();
      for (int c = 0; c < 600; c++) begin
         drive(1'($urandom_range(0, 1)),
               S'($urandom | $urandom),
               ($urandom_range(0, 7) == 0),
               RW'($urandom_range(0, 7)),
               ($urandom_range(0, 63) == 0));
         #2;
         check_model(0);
         check_model(1);
         model_step(0);
         model_step(1);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
